// File: rtl/bcd_xs3_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// bcd_xs3_seq_ctrl_if
// Bundle of the handshake and converter signals around bcd_xs3_seq_ctrl.
//
//   in_valid / in_ready / in_bcd   : BCD word input handshake (packed digits)
//   cvt_b / cvt_e                  : digit out to / result back from the shared
//                                    combinational BCD-to-Excess-3 converter
//   out_valid / out_ready          : result word output handshake
//   out_xs3 / err_mask / out_err   : packed Excess-3 result and illegal-digit flags
//   busy                           : controller is stepping through digits
//
// The slave modport is the controller's view; the master modport is the view
// of the surrounding environment (source, converter and sink together).
// ---------------------------------------------------------------------------
interface bcd_xs3_seq_ctrl_if #(
   parameter int DIGITS = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [4*DIGITS-1:0]   in_bcd;
   logic [3:0]            cvt_b;
   logic [3:0]            cvt_e;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   out_xs3;
   logic [DIGITS-1:0]     err_mask;
   logic                  out_err;
   logic                  busy;

   modport slave (
      input  in_valid, in_bcd, cvt_e, out_ready,
      output in_ready, cvt_b, out_valid, out_xs3, err_mask, out_err, busy
   );

   modport master (
      output in_valid, in_bcd, cvt_e, out_ready,
      input  in_ready, cvt_b, out_valid, out_xs3, err_mask, out_err, busy
   );
endinterface

// File: rtl/bcd_xs3_seq_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_xs3_seq_ctrl
// Sequencing controller for one shared 4-bit BCD-to-Excess-3 converter.
// A packed multi-digit BCD word is accepted over a valid/ready handshake,
// presented to the converter one digit per cycle, and the converter results
// are collected into a packed Excess-3 word. Digits above 9 are not converted:
// their result slot is written as zero and their err_mask bit is set.
//
// Parameters:
//   DIGITS    : digits per word (1..16)
//   MSD_FIRST : 0 = process digit 0 first, 1 = digit DIGITS-1 first
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : bcd_xs3_seq_ctrl_if.slave (input handshake, converter link,
//           output handshake, result, error flags, busy)
// ---------------------------------------------------------------------------
module bcd_xs3_seq_ctrl #(
   parameter int DIGITS    = 4,
   parameter bit MSD_FIRST = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   bcd_xs3_seq_ctrl_if.slave bus
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [IW-1:0] START_IDX = MSD_FIRST ? IW'(DIGITS - 1) : '0;
   localparam logic [IW-1:0] LAST_IDX  = MSD_FIRST ? '0 : IW'(DIGITS - 1);
   localparam logic [IW-1:0] IDX_ONE   = IW'(1);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [W-1:0]     bcd_q;
   logic [W-1:0]     result_q;
   logic [DIGITS-1:0] err_q;
   logic [IW-1:0]    idx_q;

   logic [3:0]       cur_digit;
   logic             accept;
   logic             in_ready_c;
   logic             out_valid_c;
   logic             busy_c;
   logic [3:0]       cvt_b_c;

   // The digit under conversion is selected from the latched word by the
   // registered index, so cvt_b never depends on the live in_bcd pins.
   assign cur_digit = bcd_q[{idx_q, 2'b00} +: 4];

   assign accept = bus.in_valid & in_ready_c;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake outputs. in_ready is gated with rst_n so the
   // source never sees a ready while the controller is held in reset. In DONE
   // the ready follows out_ready, which lets a waiting word be accepted on
   // the very edge the result leaves (no IDLE bubble between words).
   always_comb begin
      state_d     = state_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      busy_c      = 1'b0;
      cvt_b_c     = 4'h0;
      case (state_q)
         IDLE: begin
            in_ready_c = rst_n;
            if (bus.in_valid && rst_n) begin
               state_d = CONV;
            end
         end
         CONV: begin
            busy_c  = 1'b1;
            cvt_b_c = cur_digit;
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid_c = 1'b1;
            in_ready_c  = bus.out_ready & rst_n;
            if (bus.out_ready) begin
               state_d = bus.in_valid ? CONV : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath: latch the word and clear the result on accept, then write one
   // converter result (or zero plus an error flag) per CONV cycle. The
   // result and error mask are left alone after the output handshake so a
   // sink may still read them until the next word is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_q    <= '0;
         result_q <= '0;
         err_q    <= '0;
         idx_q    <= '0;
      end else if (accept) begin
         bcd_q    <= bus.in_bcd;
         result_q <= '0;
         err_q    <= '0;
         idx_q    <= START_IDX;
      end else if (state_q == CONV) begin
         if (cur_digit > 4'd9) begin
            result_q[{idx_q, 2'b00} +: 4] <= 4'h0;
            err_q[idx_q]                  <= 1'b1;
         end else begin
            result_q[{idx_q, 2'b00} +: 4] <= bus.cvt_e;
         end
         if (idx_q != LAST_IDX) begin
            idx_q <= MSD_FIRST ? (idx_q - IDX_ONE) : (idx_q + IDX_ONE);
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.busy      = busy_c;
   assign bus.cvt_b     = cvt_b_c;
   assign bus.out_xs3   = result_q;
   assign bus.err_mask  = err_q;
   assign bus.out_err   = |err_q;

endmodule
